// File: rtl/iir_coef_bank.sv
// iir_coef_bank: coefficient bank and sample re-timer for the first-order IIR filter.
// Writes land in a shadow set; the whole set moves to the active outputs in a single
// edge, and only on a sample boundary, so the filter never sees mixed coefficients.
// Optional build macro: IIR_COEF_STAB_CHECK_EN rejects a commit whose shadow a1 is
// the most negative value (-1.0), since that pole sits on the unit circle.
module iir_coef_bank #(
    parameter int unsigned     W      = 16,
    parameter logic [W-1:0]    B0_RST = 16'h4000,
    parameter logic [W-1:0]    B1_RST = 16'h0000,
    parameter logic [W-1:0]    A1_RST = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [1:0]    wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          commit_req,
    input  logic          sample_tick,
    input  logic [W-1:0]  x_in,
    output logic [W-1:0]  x,
    output logic [W-1:0]  b0,
    output logic [W-1:0]  b1,
    output logic [W-1:0]  a1,
    output logic          busy,
    output logic          commit_done,
    output logic          err,
    output logic [15:0]   tick_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [W-1:0] A1_MIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic [15:0]  TICK_MAX = 16'hFFFF;

    state_t         state_q, state_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   b0_q, b0_d;
    logic [W-1:0]   b1_q, b1_d;
    logic [W-1:0]   a1_q, a1_d;
    logic [W-1:0]   sh_b0_q, sh_b0_d;
    logic [W-1:0]   sh_b1_q, sh_b1_d;
    logic [W-1:0]   sh_a1_q, sh_a1_d;
    logic           busy_q, busy_d;
    logic           commit_done_q, commit_done_d;
    logic           err_q, err_d;
    logic [15:0]    tick_cnt_q, tick_cnt_d;
    logic           commit_now;
    logic           reject;

    // Next-state logic: sample capture, shadow writes, commit sequencing and tick counting
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        b0_d          = b0_q;
        b1_d          = b1_q;
        a1_d          = a1_q;
        sh_b0_d       = sh_b0_q;
        sh_b1_d       = sh_b1_q;
        sh_a1_d       = sh_a1_q;
        commit_done_d = 1'b0;
        err_d         = 1'b0;
        tick_cnt_d    = tick_cnt_q;
        commit_now    = 1'b0;
        reject        = 1'b0;

        if (sample_tick) begin
            x_d = x_in;
        end

        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    case (wr_addr)
                        2'd0:    sh_b0_d = wr_data;
                        2'd1:    sh_b1_d = wr_data;
                        2'd2:    sh_a1_d = wr_data;
                        default: err_d   = 1'b1;
                    endcase
                end
                if (commit_req) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (wr_en) begin
                    err_d = 1'b1;
                end
                if (sample_tick) begin
                    state_d = IDLE;
`ifdef IIR_COEF_STAB_CHECK_EN
                    if (sh_a1_q == A1_MIN) begin
                        reject = 1'b1;
                    end
`else
                    reject = 1'b0;
`endif
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        commit_now    = 1'b1;
                        b0_d          = sh_b0_q;
                        b1_d          = sh_b1_q;
                        a1_d          = sh_a1_q;
                        commit_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (sample_tick) begin
            if (commit_now) begin
                tick_cnt_d = 16'h0000;
            end else if (tick_cnt_q != TICK_MAX) begin
                tick_cnt_d = tick_cnt_q + 16'h0001;
            end
        end

        busy_d = (state_d == ARMED);
    end

    // State register with synchronous active-low reset; reset also abandons a pending commit
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            x_q           <= '0;
            b0_q          <= B0_RST;
            b1_q          <= B1_RST;
            a1_q          <= A1_RST;
            sh_b0_q       <= B0_RST;
            sh_b1_q       <= B1_RST;
            sh_a1_q       <= A1_RST;
            busy_q        <= 1'b0;
            commit_done_q <= 1'b0;
            err_q         <= 1'b0;
            tick_cnt_q    <= 16'h0000;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            b0_q          <= b0_d;
            b1_q          <= b1_d;
            a1_q          <= a1_d;
            sh_b0_q       <= sh_b0_d;
            sh_b1_q       <= sh_b1_d;
            sh_a1_q       <= sh_a1_d;
            busy_q        <= busy_d;
            commit_done_q <= commit_done_d;
            err_q         <= err_d;
            tick_cnt_q    <= tick_cnt_d;
        end
    end

    assign x           = x_q;
    assign b0          = b0_q;
    assign b1          = b1_q;
    assign a1          = a1_q;
    assign busy        = busy_q;
    assign commit_done = commit_done_q;
    assign err         = err_q;
    assign tick_cnt    = tick_cnt_q;

endmodule
